// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority-vote bit sampling.
//
// Frame: start bit, DATA_W data bits (LSB first), optional parity bit, one stop bit.
// Each bit lasts OVS sample ticks. A tick is one sysclk cycle in PSCALER. Each bit is
// decided by a 2-of-3 vote taken at ticks OVS/2-1, OVS/2 and OVS/2+1 of that bit.
//
// Ports:
//   sysclk        system clock, rising edge
//   reset         synchronous active-high reset
//   rx_i          asynchronous serial input, idle high
//   parity_en_i   parity bit present (latched at start-bit detect)
//   parity_odd_i  1 = odd parity, 0 = even (latched at start-bit detect)
//   data_o        received word, stable while valid_o
//   valid_o       word available, held until ready_i
//   ready_i       consumer accepts on valid_o & ready_i
//   parity_err_o  parity mismatch for the word on data_o
//   frame_err_o   stop bit voted 0 for the word on data_o
//   overrun_o     1-cycle pulse when a completed word is dropped
//   busy_o        receiver is inside a frame
//   break_o       line break seen (only with UART_RX_BREAK_DET_EN)
//
// Build option: define UART_RX_BREAK_DET_EN to turn all-zero frames with a zero stop
// bit into a break indication instead of a data word. Without it, break_o is tied 0.
module uart_rx_os #(
   parameter int unsigned PSCALER = 625,
   parameter int unsigned OVS     = 10,
   parameter int unsigned DATA_W  = 8
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              rx_i,
   input  logic              parity_en_i,
   input  logic              parity_odd_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              parity_err_o,
   output logic              frame_err_o,
   output logic              overrun_o,
   output logic              busy_o,
   output logic              break_o
);

   localparam int unsigned PW = (PSCALER > 1) ? $clog2(PSCALER) : 1;
   localparam int unsigned CW = $clog2(OVS);
   localparam int unsigned BW = $clog2(DATA_W);

   localparam logic [PW-1:0] PresLast = PW'(PSCALER - 1);
   localparam logic [CW-1:0] CntLast  = CW'(OVS - 1);
   localparam logic [CW-1:0] TapA     = CW'(OVS / 2 - 1);
   localparam logic [CW-1:0] TapB     = CW'(OVS / 2);
   localparam logic [CW-1:0] TapC     = CW'(OVS / 2 + 1);
   localparam logic [BW-1:0] BitLast  = BW'(DATA_W - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e            state_q, state_d;
   logic              sync1_q, sync1_d, sync2_q, sync2_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              vote_a_q, vote_a_d, vote_b_q, vote_b_d;
   logic              par_en_q, par_en_d, par_odd_q, par_odd_d;
   logic              pend_perr_q, pend_perr_d;   // parity result of the frame in flight
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              perr_q, perr_d, ferr_q, ferr_d;
   logic              ovr_q, ovr_d;

   logic              rx_s, tick, at_vote, maj, deliver, hold_idle;

   assign rx_s    = sync2_q;
   assign tick    = (presc_q == PresLast);
   assign at_vote = tick && (cnt_q == TapC);
   // Third vote is the live sample on the last tap tick.
   assign maj     = (vote_a_q & vote_b_q) | (vote_a_q & rx_s) | (vote_b_q & rx_s);

`ifdef UART_RX_BREAK_DET_EN
   logic brk_q, brk_d;
   assign hold_idle = brk_q;
   assign break_o   = brk_q;
`else
   assign hold_idle = 1'b0;
   assign break_o   = 1'b0;
`endif

   always_comb begin
      sync1_d     = rx_i;
      sync2_d     = sync1_q;
      presc_d     = tick ? '0 : presc_q + 1'b1;
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      vote_a_d    = (tick && cnt_q == TapA) ? rx_s : vote_a_q;
      vote_b_d    = (tick && cnt_q == TapB) ? rx_s : vote_b_q;
      par_en_d    = par_en_q;
      par_odd_d   = par_odd_q;
      pend_perr_d = pend_perr_q;
      data_d      = data_q;
      valid_d     = valid_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      ovr_d       = 1'b0;
      deliver     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_d       = (brk_q && rx_s) ? 1'b0 : brk_q;
`endif

      if (valid_q && ready_i) valid_d = 1'b0;

      if (tick) begin
         if (state_q != StIdle) cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
         unique case (state_q)
            StIdle: begin
               if (!rx_s && !hold_idle) begin
                  state_d     = StStart;
                  cnt_d       = '0;
                  bit_d       = '0;
                  par_en_d    = parity_en_i;
                  par_odd_d   = parity_odd_i;
                  pend_perr_d = 1'b0;
               end
            end
            StStart: begin
               if (at_vote && maj) begin
                  // Start bit did not hold low through mid-bit: treat as a glitch.
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (cnt_q == CntLast) begin
                  state_d = StData;
               end
            end
            StData: begin
               if (at_vote) shift_d = {maj, shift_q[DATA_W-1:1]};
               if (cnt_q == CntLast) begin
                  if (bit_q == BitLast) state_d = par_en_q ? StParity : StStop;
                  else                  bit_d   = bit_q + 1'b1;
               end
            end
            StParity: begin
               if (at_vote) pend_perr_d = maj ^ (^shift_q) ^ par_odd_q;
               if (cnt_q == CntLast) state_d = StStop;
            end
            StStop: begin
               if (at_vote) begin
                  // Leave half a bit early so the next start edge is not missed.
                  state_d = StIdle;
                  cnt_d   = '0;
`ifdef UART_RX_BREAK_DET_EN
                  if (shift_q == '0 && !maj) brk_d   = 1'b1;
                  else                       deliver = 1'b1;
`else
                  deliver = 1'b1;
`endif
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end

      if (deliver) begin
         if (valid_q && !ready_i) begin
            ovr_d = 1'b1;
         end else begin
            data_d  = shift_q;
            perr_d  = pend_perr_q;
            ferr_d  = !maj;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q     <= StIdle;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         presc_q     <= '0;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         vote_a_q    <= 1'b0;
         vote_b_q    <= 1'b0;
         par_en_q    <= 1'b0;
         par_odd_q   <= 1'b0;
         pend_perr_q <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         presc_q     <= presc_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         vote_a_q    <= vote_a_d;
         vote_b_q    <= vote_b_d;
         par_en_q    <= par_en_d;
         par_odd_q   <= par_odd_d;
         pend_perr_q <= pend_perr_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         ovr_q       <= ovr_d;
      end
   end

`ifdef UART_RX_BREAK_DET_EN
   always_ff @(posedge sysclk) begin
      if (reset) brk_q <= 1'b0;
      else       brk_q <= brk_d;
   end
`endif

   assign data_o       = data_q;
   assign valid_o      = valid_q;
   assign parity_err_o = perr_q;
   assign frame_err_o  = ferr_q;
   assign overrun_o    = ovr_q;
   assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os (PSCALER=4, OVS=8, DATA_W=8): fixed vector table, corner-case
// sequences (glitch, overrun, reset mid-frame) and randomized frames against a frame-level
// model of expected words.
module tb_uart_rx_os;

   localparam int unsigned PSCALER = 4;
   localparam int unsigned OVS     = 8;
   localparam int unsigned DATA_W  = 8;
   localparam int          BIT     = PSCALER * OVS;

   logic              sysclk = 1'b0;
   logic              reset = 1'b1;
   logic              rx_i = 1'b1;
   logic              parity_en_i = 1'b0;
   logic              parity_odd_i = 1'b0;
   logic              ready_i = 1'b1;
   logic [DATA_W-1:0] data_o;
   logic              valid_o, parity_err_o, frame_err_o, overrun_o, busy_o, break_o;

   int checks = 0;
   int errors = 0;
   int ovr_cnt = 0;
   bit busy_seen = 1'b0;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } word_t;

   word_t got_q[$];

   typedef struct {
      string      name;
      logic [7:0] d;
      bit         pen;
      bit         podd;
      bit         pbit;
      bit         stopb;
      logic [7:0] exp_d;
      bit         exp_pe;
      bit         exp_fe;
   } vec_t;

   uart_rx_os #(
      .PSCALER(PSCALER),
      .OVS    (OVS),
      .DATA_W (DATA_W)
   ) dut (
      .sysclk      (sysclk),
      .reset       (reset),
      .rx_i        (rx_i),
      .parity_en_i (parity_en_i),
      .parity_odd_i(parity_odd_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .parity_err_o(parity_err_o),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
      .busy_o      (busy_o),
      .break_o     (break_o)
   );

   always #5 sysclk = ~sysclk;

   // Inputs change 1 time unit after posedge, so at negedge they equal what the next
   // posedge will see; an accepted word is recorded here.
   always @(negedge sysclk) begin
      word_t w;
      if (!reset && valid_o && ready_i) begin
         w.d  = data_o;
         w.pe = parity_err_o;
         w.fe = frame_err_o;
         got_q.push_back(w);
      end
      if (overrun_o) ovr_cnt++;
      if (busy_o) busy_seen = 1'b1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx_i = b;
      cyc(BIT);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd,
                             input bit pbit, input bit stopb);
      parity_en_i  = pen;
      parity_odd_i = podd;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (pen) send_bit(pbit);
      send_bit(stopb);
      rx_i = 1'b1;
      cyc(2 * BIT);
   endtask

   task automatic expect_word(input string name, input logic [7:0] d, input logic pe,
                              input logic fe);
      word_t w;
      int    n;
      n = 0;
      while (got_q.size() == 0 && n < 4 * BIT) begin
         cyc(1);
         n++;
      end
      checks++;
      if (got_q.size() != 1) begin
         errors++;
         $display("FAIL %s_count: got %0d words required 1", name, got_q.size());
         got_q.delete();
      end else begin
         w = got_q.pop_front();
         check({name, "_data"}, 32'(w.d), 32'(d));
         check({name, "_perr"}, 32'(w.pe), 32'(pe));
         check({name, "_ferr"}, 32'(w.fe), 32'(fe));
      end
   endtask

   initial begin
      vec_t       vecs[10];
      logic [7:0] rd;
      bit         rpen, rpodd, rpbit, rstop, rexp_pe, rbrk;

      vecs[0] = '{"x55",          8'h55, 0, 0, 0, 1, 8'h55, 0, 0};
      vecs[1] = '{"a3_even_bad",  8'hA3, 1, 0, 1, 1, 8'hA3, 1, 0};
      vecs[2] = '{"x3c_stop0",    8'h3C, 0, 0, 0, 0, 8'h3C, 0, 1};
      vecs[3] = '{"a3_even_ok",   8'hA3, 1, 0, 0, 1, 8'hA3, 0, 0};
      vecs[4] = '{"x07_odd_ok",   8'h07, 1, 1, 0, 1, 8'h07, 0, 0};
      vecs[5] = '{"x07_odd_bad",  8'h07, 1, 1, 1, 1, 8'h07, 1, 0};
      vecs[6] = '{"xff",          8'hFF, 0, 0, 0, 1, 8'hFF, 0, 0};
      vecs[7] = '{"x80_ev_stop0", 8'h80, 1, 0, 1, 0, 8'h80, 0, 1};
      vecs[8] = '{"x00",          8'h00, 0, 0, 0, 1, 8'h00, 0, 0};
      vecs[9] = '{"xc1_odd_bad",  8'hC1, 1, 1, 1, 0, 8'hC1, 1, 1};

      // Reset state
      cyc(3);
      check("rst_data", 32'(data_o), 0);
      check("rst_valid", 32'(valid_o), 0);
      check("rst_perr", 32'(parity_err_o), 0);
      check("rst_ferr", 32'(frame_err_o), 0);
      check("rst_ovr", 32'(overrun_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_break", 32'(break_o), 0);
      reset = 1'b0;
      cyc(5);
      check("idle_busy", 32'(busy_o), 0);

      // Vector table
      for (int i = 0; i < 10; i++) begin
         send_frame(vecs[i].d, vecs[i].pen, vecs[i].podd, vecs[i].pbit, vecs[i].stopb);
         expect_word(vecs[i].name, vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe);
         check({vecs[i].name, "_break"}, 32'(break_o), 0);
      end

      // Start glitch: low for two ticks only
      cyc(BIT);
      busy_seen = 1'b0;
      rx_i = 1'b0;
      cyc(2 * PSCALER);
      rx_i = 1'b1;
      cyc(2 * BIT);
      check("glitch_busy_seen", 32'(busy_seen), 1);
      check("glitch_busy_end", 32'(busy_o), 0);
      check("glitch_no_word", got_q.size(), 0);

      // Overrun: 0x11 then 0x22 with consumer stalled
      ovr_cnt = 0;
      ready_i = 1'b0;
      send_frame(8'h11, 0, 0, 0, 1);
      check("ovr_valid1", 32'(valid_o), 1);
      check("ovr_data1", 32'(data_o), 32'h11);
      check("ovr_none_yet", ovr_cnt, 0);
      send_frame(8'h22, 0, 0, 0, 1);
      check("ovr_pulse_cycles", ovr_cnt, 1);
      check("ovr_data_held", 32'(data_o), 32'h11);
      check("ovr_valid_held", 32'(valid_o), 1);
      check("ovr_nothing_taken", got_q.size(), 0);
      ready_i = 1'b1;
      cyc(2);
      check("ovr_valid_clr", 32'(valid_o), 0);
      expect_word("ovr_take", 8'h11, 0, 0);

      // Reset during bit 4 of 0xF0, then 0x0F
      parity_en_i = 1'b0;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      rx_i = 1'b1;
      cyc(BIT / 2);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      check("midrst_busy", 32'(busy_o), 0);
      check("midrst_valid", 32'(valid_o), 0);
      cyc(BIT / 2);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      cyc(2 * BIT);
      check("midrst_no_word", got_q.size(), 0);
      send_frame(8'h0F, 0, 0, 0, 1);
      expect_word("after_rst", 8'h0F, 0, 0);

      // Randomized frames against the frame-level model
      for (int i = 0; i < 16; i++) begin
         rd      = 8'($urandom);
         rpen    = 1'($urandom_range(0, 1));
         rpodd   = 1'($urandom_range(0, 1));
         rpbit   = 1'($urandom_range(0, 1));
         rstop   = ($urandom_range(0, 3) != 0);
         rexp_pe = rpen ? ((^rd) ^ rpbit ^ rpodd) : 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         rbrk    = (rd == 8'h00) && !rstop;
`else
         rbrk    = 1'b0;
`endif
         cyc($urandom_range(0, 7));
         send_frame(rd, rpen, rpodd, rpbit, rstop);
         if (rbrk) check("rnd_break_no_word", got_q.size(), 0);
         else      expect_word("rnd", rd, rexp_pe, !rstop);
      end

      check("total_overruns", ovr_cnt, 1);
      check("end_busy", 32'(busy_o), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
